// File: rtl/vga_timing_pkg.sv
// 640x480@60 Hz VGA timing constants shared by the sync generator and the pixel generator.
package vga_timing_pkg;

    localparam int CLK_DIV   = 4;
    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    // Inclusive window test used for the sync pulse decode.
    function automatic logic in_range(coord_t c, coord_t lo, coord_t hi);
        return (c >= lo) && (c <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_if.sv
// Timing bundle from vga_sync to the pixel generator; every signal is produced by the master.
interface vga_sync_if;
    import vga_timing_pkg::*;

    logic   hsync;
    logic   vsync;
    logic   video_on;
    logic   p_tick;
    logic   frame_tick;
    coord_t x;
    coord_t y;

    // No handshake: consumers act only on cycles where p_tick (or frame_tick) is high.
    modport master (output hsync, vsync, video_on, p_tick, frame_tick, x, y);
    modport slave  (input  hsync, vsync, video_on, p_tick, frame_tick, x, y);

endinterface

// File: rtl/vga_sync_pixel_tick_div.sv
// Mod-CLK_DIV counter; p_tick is high on the last count, i.e. one clk in every CLK_DIV.
module pixel_tick_div #(
    parameter int CLK_DIV = vga_timing_pkg::CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    assign p_tick = (div == DIV_LAST);

endmodule

// File: rtl/vga_sync.sv
// VGA timing generator: pixel-rate h/v counters, registered active-low syncs, frame tick.
module vga_sync #(
    parameter int CLK_DIV   = vga_timing_pkg::CLK_DIV,
    parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
    input  logic          clk,
    input  logic          reset,
    vga_sync_if.master    vga
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam vga_timing_pkg::coord_t H_LAST    = vga_timing_pkg::coord_t'(H_TOTAL - 1);
    localparam vga_timing_pkg::coord_t V_LAST    = vga_timing_pkg::coord_t'(V_TOTAL - 1);
    localparam vga_timing_pkg::coord_t H_VIS     = vga_timing_pkg::coord_t'(H_DISPLAY);
    localparam vga_timing_pkg::coord_t V_VIS     = vga_timing_pkg::coord_t'(V_DISPLAY);
    localparam vga_timing_pkg::coord_t V_VIS_END = vga_timing_pkg::coord_t'(V_DISPLAY - 1);
    localparam vga_timing_pkg::coord_t HS_START  = vga_timing_pkg::coord_t'(H_DISPLAY + H_FRONT);
    localparam vga_timing_pkg::coord_t HS_END    = vga_timing_pkg::coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam vga_timing_pkg::coord_t VS_START  = vga_timing_pkg::coord_t'(V_DISPLAY + V_FRONT);
    localparam vga_timing_pkg::coord_t VS_END    = vga_timing_pkg::coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic                   p_tick;
    vga_timing_pkg::coord_t h, v;
    vga_timing_pkg::coord_t h_next, v_next;
    logic                   hsync_q, vsync_q;

    pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick)
    );

    always_comb begin
        h_next = h;
        v_next = v;
        if (p_tick) begin
            if (h == H_LAST) begin
                h_next = '0;
                v_next = (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
                h_next = h + 1'b1;
            end
        end
    end

    // Syncs decode the next counter values so the registered pins line up with x/y.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h       <= '0;
            v       <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            h       <= h_next;
            v       <= v_next;
            hsync_q <= !vga_timing_pkg::in_range(h_next, HS_START, HS_END);
            vsync_q <= !vga_timing_pkg::in_range(v_next, VS_START, VS_END);
        end
    end

    assign vga.x          = h;
    assign vga.y          = v;
    assign vga.hsync      = hsync_q;
    assign vga.vsync      = vsync_q;
    assign vga.p_tick     = p_tick;
    assign vga.video_on   = (h < H_VIS) && (v < V_VIS);
    assign vga.frame_tick = p_tick && (h == H_LAST) && (v == V_VIS_END);

endmodule
